// File: rtl/strobe_tx_handshake_if.sv
// Handshake bundle for strobe_tx_handshake: upstream valid/ready words, the
// strobe/data launch toward the crossing, the returned ack toggle and status.
interface strobe_tx_handshake_if #(
    parameter int unsigned WIDTH = 8
);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             strobe_out;
    logic [WIDTH-1:0] data_out;
    logic             ack_toggle_in;
    logic             busy;
    logic             timeout_err;
    logic             err_clr;

    modport master (
        output s_valid, s_data, ack_toggle_in, err_clr,
        input  s_ready, strobe_out, data_out, busy, timeout_err
    );

    modport slave (
        input  s_valid, s_data, ack_toggle_in, err_clr,
        output s_ready, strobe_out, data_out, busy, timeout_err
    );
endinterface

// File: rtl/strobe_tx_handshake.sv
// Sending side of a toggle-flag strobe crossing: one word in flight, ack toggle
// synchronised locally, lost acks flagged by timeout. STROBE_TX_SKID_EN adds a one-word hold.
module strobe_tx_handshake #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DELAY   = 2,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    strobe_tx_handshake_if.slave bus
);
    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WAIT} state_e;

    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(DELAY);
    localparam logic [CNT_W-1:0] TO_LAST   = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DELAY-1:0]   sync_q, sync_d;
    logic               ack_prev_q, ack_prev_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               strobe_q, strobe_d;
    logic               err_q, err_d;
    logic               ack_edge;
    logic               timeout_hit;
    logic               s_ready;
    logic               accept;
`ifdef STROBE_TX_SKID_EN
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_valid_q, hold_valid_d;

    assign s_ready = (state_q == ST_IDLE) || ((state_q == ST_WAIT) && !hold_valid_q);
`else
    assign s_ready = (state_q == ST_IDLE);
`endif

    assign accept          = bus.s_valid & s_ready;
    assign bus.s_ready     = s_ready;
    assign bus.strobe_out  = strobe_q;
    assign bus.data_out    = data_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.timeout_err = err_q;

    always_comb begin
        sync_d      = {sync_q[DELAY-2:0], bus.ack_toggle_in};
        ack_prev_d  = sync_q[DELAY-1];
        ack_edge    = sync_q[DELAY-1] ^ ack_prev_q;
        timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST) && !ack_edge;
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        strobe_d    = 1'b0;
        err_d       = err_q & ~bus.err_clr;
`ifdef STROBE_TX_SKID_EN
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
`endif
        unique case (state_q)
            // Let the chain and ack_prev settle on the far side's current level.
            ST_INIT: begin
                if (cnt_q == INIT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    data_d   = bus.s_data;
                    strobe_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                if (timeout_hit) err_d = 1'b1;
                if (ack_edge || timeout_hit) begin
`ifdef STROBE_TX_SKID_EN
                    // Relaunch straight from the hold (or a word arriving now) without an idle gap.
                    if (hold_valid_q) begin
                        data_d       = hold_q;
                        strobe_d     = 1'b1;
                        cnt_d        = '0;
                        hold_valid_d = 1'b0;
                    end else if (accept) begin
                        data_d   = bus.s_data;
                        strobe_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
`ifdef STROBE_TX_SKID_EN
                else if (accept) begin
                    hold_d       = bus.s_data;
                    hold_valid_d = 1'b1;
                end
`endif
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            sync_q     <= '0;
            ack_prev_q <= 1'b0;
            data_q     <= '0;
            strobe_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sync_q     <= sync_d;
            ack_prev_q <= ack_prev_d;
            data_q     <= data_d;
            strobe_q   <= strobe_d;
            err_q      <= err_d;
        end
    end

`ifdef STROBE_TX_SKID_EN
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end
`endif
endmodule

// File: tb/tb_strobe_tx_handshake.sv
// Directed plus randomized bench for strobe_tx_handshake (DELAY=2, TIMEOUT=10);
// the hold-register sequence runs only when STROBE_TX_SKID_EN is defined.
module tb_strobe_tx_handshake;
    localparam int unsigned W   = 8;
    localparam int          DLY = 2;
    localparam int          TO  = 10;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;

    strobe_tx_handshake_if #(.WIDTH(W)) bus ();

    strobe_tx_handshake #(
        .WIDTH  (W),
        .DELAY  (DLY),
        .TIMEOUT(TO),
        .CNT_W  (8)
    ) dut (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    int         checks = 0;
    int         errors = 0;
    logic       model_err = 1'b0;
    logic       ack_lvl = 1'b1;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];

    // Every launched word seen by the crossing, sampled mid-cycle.
    always @(negedge clk_in) if (bus.strobe_out === 1'b1) got_q.push_back(bus.data_out);

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic toggle_ack();
        ack_lvl = ~ack_lvl;
        bus.ack_toggle_in = ack_lvl;
    endtask

    task automatic clear_err();
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        model_err = 1'b0;
        chk("err_clr", bus.timeout_err, model_err);
    endtask

    // One word from IDLE; lat = cycles after launch edge at which the ack toggles (<0: never).
    // Ack is taken lat+DELAY edges after launch unless the timeout at edge TIMEOUT comes first.
    task automatic transact(input logic [W-1:0] word, input int lat, input bit clr_at_end);
        bit timed_out;
        int end_edge;
        timed_out = (lat < 0) || (lat + DLY > TO);
        end_edge  = timed_out ? TO : lat + DLY;
        bus.s_valid = 1'b1;
        bus.s_data  = word;
        step();
        bus.s_valid = 1'b0;
        bus.s_data  = W'($urandom);
        exp_q.push_back(word);
        chk("launch_strobe", bus.strobe_out, 1);
        chk("launch_data", bus.data_out, word);
        chk("launch_ready", bus.s_ready, 0);
        for (int j = 1; j <= end_edge; j++) begin
            if (lat > 0 && j == lat) toggle_ack();
            if (clr_at_end && j == end_edge) bus.err_clr = 1'b1;
            step();
            bus.err_clr = 1'b0;
            if (j == end_edge) begin
                if (timed_out) model_err = 1'b1;
                else if (clr_at_end) model_err = 1'b0;
                chk("done_ready", bus.s_ready, 1);
                chk("done_busy", bus.busy, 0);
                chk("done_err", bus.timeout_err, model_err);
                chk("done_strobe", bus.strobe_out, 0);
            end else begin
                chk("wait_ready", bus.s_ready, 0);
                chk("wait_data", bus.data_out, word);
                chk("wait_strobe", bus.strobe_out, 0);
            end
        end
        // A late ack still crosses; let it land while IDLE before the next word.
        if (timed_out && lat > 0) begin
            for (int j = 0; j < DLY + 1; j++) begin
                step();
                chk("late_ack_ready", bus.s_ready, 1);
                chk("late_ack_busy", bus.busy, 0);
            end
        end
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        chk("init_ready_c0", bus.s_ready, 0);
        step();
        chk("init_ready_c1", bus.s_ready, 0);
        step();
        chk("init_ready_c2", bus.s_ready, 0);
        chk("init_busy_c2", bus.busy, 1);
        step();
        chk("init_ready_c3", bus.s_ready, 1);
        chk("init_busy_c3", bus.busy, 0);
        chk("init_strobe", bus.strobe_out, 0);
    endtask

    initial begin
        bus.s_valid       = 1'b0;
        bus.s_data        = '0;
        bus.ack_toggle_in = ack_lvl;
        bus.err_clr       = 1'b0;
        step();
        step();
        chk("rst_ready", bus.s_ready, 0);
        chk("rst_strobe", bus.strobe_out, 0);
        chk("rst_data", bus.data_out, 0);
        chk("rst_busy", bus.busy, 1);
        chk("rst_err", bus.timeout_err, 0);
        release_reset();

        transact(8'hA5, 6, 1'b0);
        transact(8'h3C, -1, 1'b0);
        clear_err();
        transact(8'h5A, 8, 1'b0);
        transact(8'h77, -1, 1'b1);
        clear_err();

        for (int i = 0; i < 3; i++) begin
            toggle_ack();
            step();
            step();
            chk("spurious_ready", bus.s_ready, 1);
            chk("spurious_busy", bus.busy, 0);
            chk("spurious_err", bus.timeout_err, 0);
        end
        for (int i = 0; i < DLY + 1; i++) step();
        transact(8'h11, 4, 1'b0);

        for (int i = 0; i < 16; i++) begin
            int r;
            if ($urandom_range(0, 3) == 0) clear_err();
            r = int'($urandom_range(0, 9));
            transact(W'($urandom), (r == 0) ? -1 : r, 1'b0);
        end

        // Reset during the launch cycle drops the word and kills the strobe at once.
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hC3;
        step();
        bus.s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_strobe", bus.strobe_out, 0);
        chk("midrst_data", bus.data_out, 0);
        chk("midrst_busy", bus.busy, 1);
        chk("midrst_err", bus.timeout_err, 0);
        model_err = 1'b0;
        step();
        release_reset();
        transact(8'h96, 3, 1'b0);

`ifdef STROBE_TX_SKID_EN
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h01;
        step();
        chk("skid_launch1", bus.data_out, 8'h01);
        chk("skid_strobe1", bus.strobe_out, 1);
        chk("skid_ready_empty", bus.s_ready, 1);
        bus.s_data = 8'h02;
        step();
        chk("skid_ready_full", bus.s_ready, 0);
        chk("skid_hold_data", bus.data_out, 8'h01);
        bus.s_data = 8'h03;
        toggle_ack();
        step();
        chk("skid_full_c2", bus.s_ready, 0);
        step();
        chk("skid_full_c3", bus.s_ready, 0);
        step();
        chk("skid_launch2", bus.data_out, 8'h02);
        chk("skid_strobe2", bus.strobe_out, 1);
        chk("skid_busy2", bus.busy, 1);
        step();
        bus.s_valid = 1'b0;
        chk("skid_ready_full2", bus.s_ready, 0);
        chk("skid_strobe_low", bus.strobe_out, 0);
        toggle_ack();
        step();
        step();
        step();
        chk("skid_launch3", bus.data_out, 8'h03);
        chk("skid_strobe3", bus.strobe_out, 1);
        toggle_ack();
        step();
        step();
        step();
        chk("skid_idle_ready", bus.s_ready, 1);
        chk("skid_idle_busy", bus.busy, 0);
        chk("skid_err", bus.timeout_err, model_err);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
`endif

        step();
        chk("launch_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk("launch_order", got_q[i], exp_q[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/strobe_tx_handshake.md
Name: strobe_tx_handshake

Overview:
Sending-side controller for the toggle-flag strobe clock crossing.
- Accepts words on a valid/ready interface in the clk_in domain.
- Launches each word to the crossing as `data_out` plus a one-cycle `strobe_out` pulse, and holds `data_out` stable until the far domain returns an acknowledge toggle.
- Synchronises the returned `ack_toggle_in` locally, paces transfers to one outstanding word, and flags lost acknowledges with a timeout.

Parameters:
- WIDTH, 8, data word width.
- DELAY, 2, synchroniser depth for `ack_toggle_in` (minimum 2).
- TIMEOUT, 255, maximum clk_in cycles spent waiting for an ack; 0 disables the timeout.
- CNT_W, 8, width of the timeout counter; TIMEOUT must be ≤ 2^CNT_W − 1.

Ports:
- clk_in  input  1  sole clock.
- rst_n  input  1  asynchronous, active-low reset.
- s_valid  input  1  upstream word valid.
- s_ready  output  1  block can accept a word.
- s_data  input  WIDTH  upstream word.
- strobe_out  output  1  one-cycle launch pulse to the crossing.
- data_out  output  WIDTH  launched word, held stable until ack or timeout.
- ack_toggle_in  input  1  asynchronous ack; toggles once per word consumed in the far domain.
- busy  output  1  state != IDLE.
- timeout_err  output  1  sticky; set when a timeout fires.
- err_clr  input  1  synchronous clear of `timeout_err`.

Behaviour:
- Reset values: s_ready=0, strobe_out=0, data_out=0, busy=1, timeout_err=0, sync chain=0, ack_prev=0, counter=0, state=INIT.
- Ack synchroniser: `sync <= {sync[DELAY-2:0], ack_toggle_in}` every cycle. `ack_prev <= sync[DELAY-1]`. `ack_edge = sync[DELAY-1] ^ ack_prev`.
- INIT: count DELAY+1 cycles so the chain and ack_prev fill with the current ack level; `ack_edge` is ignored in this state; then go to IDLE. This avoids a false edge when the far side is out of reset at a toggle level of 1.
- IDLE: s_ready=1.
  - On `s_valid & s_ready` at edge N: `data_out <= s_data`, `strobe_out <= 1` (high for exactly the cycle after edge N), counter cleared, go to WAIT.
  - An `ack_edge` seen in IDLE is spurious; it is ignored, with no state or flag change.
- WAIT: s_ready=0, data_out held, counter increments by 1 per cycle and saturates.
  - `ack_edge` → IDLE. If `ack_toggle_in` toggles just before edge k, s_ready is high after edge k+DELAY.
  - TIMEOUT≠0 and counter==TIMEOUT−1 with no `ack_edge` → `timeout_err <= 1`, go to IDLE; the word is abandoned.
- Simultaneous events:
  - `ack_edge` and timeout in the same cycle: ack wins, no error.
  - `err_clr` and a timeout in the same cycle: set wins.
- Throughput without the optional feature: one word per (DELAY+2+far-side latency) cycles; never more than one word outstanding.
- Reset asserted mid-WAIT: all registers return to reset values immediately; `strobe_out` is forced low asynchronously; the in-flight word is dropped.

Optional Feature:
- Macro: STROBE_TX_SKID_EN.
- Defined:
  - Adds a one-entry holding register plus valid bit.
  - In WAIT, s_ready = !hold_valid; an accepted word goes into hold.
  - On `ack_edge` with hold_valid=1: the held word is launched on that same edge (`data_out <= hold`, `strobe_out <= 1`), the state stays in WAIT, the counter is cleared, and hold_valid is cleared.
  - On timeout, the held word is launched the same way and `timeout_err` is set.
  - Reset clears hold_valid.
- Undefined: no holding register; s_ready=0 throughout WAIT.

Test Plan:
- Reset release with ack_toggle_in=1, DELAY=2 → s_ready stays 0 for 3 cycles, then 1; no launch; busy falls with s_ready.
- Send 0xA5; ack toggles 6 cycles after the strobe → strobe_out high exactly 1 cycle; data_out=0xA5 until IDLE; s_ready returns 2 cycles after the toggle; timeout_err=0.
- TIMEOUT=10; send 0x3C; no ack → timeout_err=1 on cycle 10 after launch; s_ready=1; err_clr pulse → timeout_err=0.
- TIMEOUT=10; ack edge aligned to counter==9 → IDLE with timeout_err=0. Also, err_clr coincident with a timeout → timeout_err=1.
- Toggle ack 3 times while IDLE, then send 0x11 → no spurious state change; transfer completes only on the next real ack.
- STROBE_TX_SKID_EN: back-to-back words 0x01, 0x02, 0x03 with s_valid held high → 0x02 is held; it launches on the ack edge of 0x01 with no idle cycle; s_ready=0 while the hold is full; all three words delivered in order.
